debug_snapshot_out: RTL

//  Parametrised debug readout: NCH data-wide probe channels sliced into OUT_W-bit words.

---
 rtl/debug_snapshot_out_pkg.sv | 21 ++
 rtl/debug_snapshot_out_if.sv | 28 ++
 rtl/debug_snapshot_out_word_mux.sv | 46 ++++
 rtl/debug_snapshot_out.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/debug_snapshot_out_pkg.sv
// Shared definitions for the debug snapshot readout block.
// Holds the snapshot FSM state encoding, the default geometry and a small
// width helper used to size select and counter fields.
package debug_snapshot_out_pkg;

    // Snapshot streamer states: IDLE waits for a request, SEND streams the frozen buffer.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } snap_state_e;

    localparam int DEF_NCH    = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_OUT_W  = 8;

    // clog2 that never returns 0, so a one-entry select still gets a 1-bit field.
    function automatic int min_one_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debug_snapshot_out_if.sv
// Valid/ready word stream carrying snapshot words to a UART/bridge feeder.
//   stream_data  : current OUT_W-bit word
//   stream_valid : word valid
//   stream_ready : sink accepts word
//   stream_last  : final word of the snapshot
// master = snapshot source, slave = sink.
interface debug_snapshot_out_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] stream_data;
    logic             stream_valid;
    logic             stream_ready;
    logic             stream_last;

    modport master (
        output stream_data,
        output stream_valid,
        output stream_last,
        input  stream_ready
    );

    modport slave (
        input  stream_data,
        input  stream_valid,
        input  stream_last,
        output stream_ready
    );
endinterface

// File: rtl/debug_snapshot_out_word_mux.sv
// debug_word_mux: combinational (channel, slice) -> OUT_W word select.
//   data_i  : NCH channels of DATA_W bits, channel k at data_i[k*DATA_W +: DATA_W]
//   sel_i   : channel select
//   slice_i : slice select, 0 = least-significant OUT_W bits
//   word_o  : selected word, 0 when sel_i >= NCH or slice_i >= SLC
module debug_word_mux
    import debug_snapshot_out_pkg::*;
#(
    parameter  int NCH    = DEF_NCH,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int OUT_W  = DEF_OUT_W,
    localparam int SLC    = DATA_W / OUT_W,
    localparam int NWORD  = NCH * SLC,
    localparam int SEL_W  = min_one_clog2(NCH),
    localparam int BSEL_W = min_one_clog2(SLC)
) (
    input  logic [NCH*DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [BSEL_W-1:0]     slice_i,
    output logic [OUT_W-1:0]      word_o
);

    // Because DATA_W is a multiple of OUT_W, word i (channel i/SLC, slice i%SLC)
    // sits contiguously at bit i*OUT_W of the flat probe vector.
    logic [OUT_W-1:0] words [NWORD];
    logic [NWORD-1:0] hit;

    generate
        for (genvar gi = 0; gi < NWORD; gi++) begin : g_word
            assign words[gi] = data_i[gi*OUT_W +: OUT_W];
            assign hit[gi]   = (sel_i == SEL_W'(gi / SLC)) &&
                               (slice_i == BSEL_W'(gi % SLC));
        end
    endgenerate

    // Out-of-range selects match no entry, so the word falls back to zero.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < NWORD; i++) begin
            if (hit[i]) begin
                word_o = words[i];
            end
        end
    end

endmodule

// File: rtl/debug_snapshot_out.sv
// debug_snapshot_out: debug readout of NCH probe channels as OUT_W-bit words.
//   clk, rst       : clock, asynchronous active-high reset
//   probes_i       : NCH*DATA_W probe bus
//   live_sel_i     : live channel select
//   live_slice_i   : live slice select
//   live_out_o     : registered live word (1 clock latency)
//   snap_req_i     : single-cycle snapshot request
//   snap_busy_o    : snapshot held / streaming
//   overrun_o      : sticky, request seen while busy
//   clr_overrun_i  : synchronous clear of overrun (a concurrent set wins)
//   strm           : valid/ready stream of snapshot words (master side)
module debug_snapshot_out
    import debug_snapshot_out_pkg::*;
#(
    parameter  int NCH    = DEF_NCH,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int OUT_W  = DEF_OUT_W,
    localparam int SLC    = DATA_W / OUT_W,
    localparam int NWORD  = NCH * SLC,
    localparam int SEL_W  = min_one_clog2(NCH),
    localparam int BSEL_W = min_one_clog2(SLC),
    localparam int CNT_W  = min_one_clog2(NWORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*DATA_W-1:0] probes_i,
    input  logic [SEL_W-1:0]      live_sel_i,
    input  logic [BSEL_W-1:0]     live_slice_i,
    output logic [OUT_W-1:0]      live_out_o,
    input  logic                  snap_req_i,
    output logic                  snap_busy_o,
    output logic                  overrun_o,
    input  logic                  clr_overrun_i,
    debug_snapshot_out_if.master  strm
);

    snap_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  overrun_q, overrun_d;
    logic [OUT_W-1:0]      live_out_q;
    logic [NCH*DATA_W-1:0] snap_buf_q;
    logic                  capture;
    logic                  is_last;
    logic [OUT_W-1:0]      live_word;
    logic [OUT_W-1:0]      strm_word;
    logic [SEL_W-1:0]      strm_sel;
    logic [BSEL_W-1:0]     strm_slice;

    // ---------------- live path ----------------
    debug_word_mux #(
        .NCH    (NCH),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_live_mux (
        .data_i  (probes_i),
        .sel_i   (live_sel_i),
        .slice_i (live_slice_i),
        .word_o  (live_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_out_q <= '0;
        end else begin
            live_out_q <= live_word;
        end
    end

    assign live_out_o = live_out_q;

    // ---------------- snapshot path ----------------
    // Buffer contents are don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap_buf_q <= probes_i;
        end
    end

    // Word index -> (channel, slice); SLC need not be a power of two.
    assign strm_sel   = SEL_W'(int'(cnt_q) / SLC);
    assign strm_slice = BSEL_W'(int'(cnt_q) % SLC);

    debug_word_mux #(
        .NCH    (NCH),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_strm_mux (
        .data_i  (snap_buf_q),
        .sel_i   (strm_sel),
        .slice_i (strm_slice),
        .word_o  (strm_word)
    );

    assign is_last = (cnt_q == CNT_W'(NWORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        capture   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stream_ready is deliberately not looked at here.
                if (snap_req_i) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (strm.stream_ready) begin
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A request while streaming (even on the final handshake) is dropped
        // and flagged; flagging takes priority over a same-cycle clear.
        if (snap_req_i && (state_q == ST_SEND)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // Stream outputs decode registered state only; data is zeroed while idle
    // so the unreset buffer never shows on the port.
    assign strm.stream_valid = (state_q == ST_SEND);
    assign strm.stream_last  = (state_q == ST_SEND) && is_last;
    assign strm.stream_data  = (state_q == ST_SEND) ? strm_word : '0;
    assign snap_busy_o       = (state_q == ST_SEND);
    assign overrun_o         = overrun_q;

endmodule
